// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int CNT_W(input int width);
    return $clog2(width + 32'sd1);
  endfunction

endpackage

// File: rtl/rc_adder.sv
// Combinational ripple-carry adder: {carry_out, sum_out} = first_term + second_term + carry_in.
module rc_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] first_term,
  input  logic [WIDTH-1:0] second_term,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  logic [WIDTH:0] carry_s;

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    carry_s    = '0;
    sum_out    = '0;
    carry_s[0] = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum_out[i]   = first_term[i] ^ second_term[i] ^ carry_s[i];
      carry_s[i+1] = (first_term[i] & second_term[i]) |
                     (carry_s[i] & (first_term[i] ^ second_term[i]));
    end
    carry_out = carry_s[WIDTH];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier: one shift-and-add step per clock through a single rc_adder.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = CNT_W(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   second_term_s, sum_s;
  logic               carry_out_s;

  rc_adder #(.WIDTH(WIDTH)) u_adder (
    .first_term  (acc_hi_q),
    .second_term (second_term_s),
    .carry_in    (1'b0),
    .sum_out     (sum_s),
    .carry_out   (carry_out_s)
  );

  // Partial-product selection and the one-bit right shift of {carry, sum, acc_lo}.
  always_comb begin
    second_term_s = '0;
    if (acc_lo_q[0]) begin
      second_term_s = mcand_q;
    end else begin
      second_term_s = '0;
    end
    acc_hi_d = {carry_out_s, sum_s[WIDTH-1:1]};
    acc_lo_d = {sum_s[0], acc_lo_q[WIDTH-1:1]};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (cnt_q == CW'(1)) state_d = DONE;
        else                 state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q  <= multiplicand;
            acc_hi_q <= '0;
            acc_lo_q <= multiplier;
            cnt_q    <= CW'(WIDTH);
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q - CW'(1);
          // Final iteration: publish the post-shift word on the edge entering DONE.
          if (cnt_q == CW'(1)) product_q <= {acc_hi_d, acc_lo_d};
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WIDTH=8.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mcand = 8'd0;
  logic [7:0]  mplier = 8'd0;
  logic        busy, done;
  logic [15:0] product;

  int checks = 0;
  int failures = 0;
  int carry_seen = 0;
  logic [15:0] prev_p = 16'd0;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (busy && dut.carry_out_s) carry_seen <= carry_seen + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full single operation from a start in the current cycle; ends in the cycle after DONE.
  task automatic mult(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_p, input string tag);
    start = 1'b1; mcand = a; mplier = b;
    tick();
    start = 1'b0; mcand = 8'($urandom); mplier = 8'($urandom);
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      chk({tag, "_nodone"}, 16'(done), 16'd0);
      chk({tag, "_hold"}, product, prev_p);
      tick();
    end
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_idle9"}, 16'(busy), 16'd0);
    chk({tag, "_prod"}, product, exp_p);
    prev_p = exp_p;
    tick();
    chk({tag, "_pulse"}, 16'(done), 16'd0);
  endtask

  initial begin
    #12;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_prod", product, 16'd0);

    // Start accepted in the very first cycle after release.
    @(negedge clk);
    resetn = 1'b1;
    mult(8'd13, 8'd11, 16'h008F, "m13x11");

    carry_seen = 0;
    mult(8'd255, 8'd255, 16'hFE01, "m255x255");
    chk("carry_used", 16'(carry_seen > 0), 16'd1);

    mult(8'd0, 8'd200, 16'd0, "m0x200");
    mult(8'd200, 8'd0, 16'd0, "m200x0");

    // Start during RUN must be ignored.
    start = 1'b1; mcand = 8'd7; mplier = 8'd6;
    tick();
    for (int c = 1; c <= 8; c++) begin
      start = (c == 3);
      mcand = (c == 3) ? 8'd9 : 8'd0;
      mplier = (c == 3) ? 8'd9 : 8'd0;
      chk("ign_busy", 16'(busy), 16'd1);
      tick();
    end
    start = 1'b0;
    chk("ign_done", 16'(done), 16'd1);
    chk("ign_prod", product, 16'd42);
    for (int c = 10; c <= 19; c++) begin
      tick();
      chk("ign_nodone", 16'({busy, done}), 16'd0);
    end

    // Back-to-back with start held high.
    start = 1'b1; mcand = 8'd3; mplier = 8'd5;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk("b2b_busy1", 16'({busy, done}), 16'd2);
      tick();
    end
    chk("b2b_done1", 16'({busy, done}), 16'd1);
    chk("b2b_prod1", product, 16'd15);
    mcand = 8'd10; mplier = 8'd10;
    tick();
    mcand = 8'd1; mplier = 8'd1;
    for (int c = 10; c <= 17; c++) begin
      chk("b2b_busy2", 16'({busy, done}), 16'd2);
      chk("b2b_hold2", product, 16'd15);
      tick();
    end
    start = 1'b0;
    chk("b2b_done2", 16'({busy, done}), 16'd1);
    chk("b2b_prod2", product, 16'd100);
    tick();
    chk("b2b_idle", 16'({busy, done}), 16'd0);
    prev_p = 16'd100;

    // Asynchronous reset in the middle of a run.
    start = 1'b1; mcand = 8'd100; mplier = 8'd100;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("arst_pre_busy", 16'(busy), 16'd1);
    resetn = 1'b0;
    #1;
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_done", 16'(done), 16'd0);
    chk("arst_prod", product, 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    prev_p = 16'd0;
    mult(8'd2, 8'd3, 16'd6, "m2x3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
